// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage blocks.
// The occupancy state encoding doubles as the occupancy count (0, 1 or 2 entries).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_stage_skid.sv
// Single pipeline stage with a skid buffer.
// The main entry drives the downstream port, and the skid entry absorbs one
// extra beat when downstream stalls. Because of that extra entry, in_ready can
// come straight from a register, so there is no combinational path from
// out_ready back to in_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] KILL_MASK = '1,
    parameter logic [DATA_W-1:0] BUBBLE    = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    occ_state_e        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              inReady_q, inReady_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
    logic              accept;
    logic              outValid;

    assign accept   = in_valid && inReady_q;
    assign outValid = (state_q != EMPTY);

    // Occupancy transitions and entry movement; flush empties the stage and discards any same-cycle input.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // in_ready is registered from the next state, and the stall counter saturates instead of wrapping.
    always_comb begin
        inReady_d  = (state_d != TWO);
        stallCnt_d = stallCnt_q;
        if (outValid && !out_ready && (stallCnt_q != CntMax)) begin
            stallCnt_d = stallCnt_q + CntOne;
        end
    end

    // State and data registers; reset takes priority over flush and every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            inReady_q  <= 1'b1;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            inReady_q  <= inReady_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid;
    assign occupancy = state_q;
    assign stall_cnt = stallCnt_q;
    assign out_data  = outValid ? main_q : ((main_q & ~KILL_MASK) | (BUBBLE & KILL_MASK));

endmodule : pipe_stage_skid
